conv_out_requant: RTL and testbench

- Downstream stage of the DSP-cascade convolution PE.
- Consumes the PE's 48-bit accumulated result stream, qualified by the PE's valid strobe, for one output feature map per frame.
- Per result: adds a per-frame bias, applies a rounding arithmetic right shift, saturates to OUT_WIDTH signed, and tags the word with (row, col).
- Buffers results in a small FIFO and presents them on a valid/ready interface to the output-buffer writer.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_result_fifo.sv | 57 +++++
 rtl/conv_out_requant.sv | 197 +++++++++++++++++++
 tb/tb_conv_out_requant.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output requantiser.
// Holds datapath widths, the FSM encoding and the output-size calculation.
package conv_pkg;

    localparam int P_WIDTH    = 48;
    localparam int BIAS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int calc_out_size(input int fm, input int k, input int pad, input int s);
        return (fm - k + 2 * pad) / s + 1;
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged results.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: a push when full is taken only if a pop occurs in the same cycle.
module conv_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // When empty, the head shows the last word popped rather than a stale slot.
    assign o_dat = o_empty ? hold_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= i_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/conv_out_requant.sv
// Bias, rounding shift and saturation of PE results, tagged with (row, col); optional ReLU via CONV_OUT_RELU_EN.
// Latency: sample accepted at edge t is written to the FIFO at edge t+3.
// Backpressure: PE stream cannot stall; words arriving at a full FIFO are dropped and flagged.
module conv_out_requant
    import conv_pkg::*;
#(
    parameter int FM_SIZE     = 2,
    parameter int KERNEL_SIZE = 1,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT       = 8,
    parameter int FIFO_DEPTH  = 16,
    localparam int OUT_SIZE   = calc_out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE),
    localparam int CW         = $clog2(OUT_SIZE) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BIAS_WIDTH-1:0] i_bias,
    input  logic [P_WIDTH-1:0]    i_P,
    input  logic                  i_P_valid,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic [CW-1:0]         o_row,
    output logic [CW-1:0]         o_col,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int SUM_W = P_WIDTH + 1;
    localparam int R_W   = P_WIDTH + 2;
    localparam int PL_W  = 2 * CW + OUT_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(OUT_SIZE - 1);
    localparam logic signed [R_W-1:0] SAT_MAX = R_W'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [R_W-1:0] SAT_MIN = -SAT_MAX - 1;

    state_t state_q, state_d;

    logic [BIAS_WIDTH-1:0] bias_q;
    logic [CW-1:0]         row_q, col_q;
    logic                  ovf_q;

    logic                  s1_vld, s2_vld, s3_vld;
    logic [SUM_W-1:0]      s1_sum;
    logic signed [R_W-1:0] s2_r;
    logic [OUT_WIDTH-1:0]  s3_dat;
    logic [CW-1:0]         s1_row, s1_col, s2_row, s2_col, s3_row, s3_col;

    logic signed [R_W-1:0] sum_ext, s2_next;
    logic [OUT_WIDTH-1:0]  sat_d;
    logic                  start_ok, accept, last_smp, pipe_idle;
    logic                  fifo_full, fifo_empty, pop, drop;
    logic [PL_W-1:0]       fifo_dat;

    assign start_ok  = (state_q == IDLE) && i_start;
    assign accept    = (state_q == RUN) && i_P_valid;
    assign last_smp  = accept && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign pipe_idle = !s1_vld && !s2_vld && !s3_vld;
    assign pop       = o_valid && i_ready;
    assign drop      = s3_vld && fifo_full && !pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_done  = 1'b0;
        case (state_q)
            IDLE:  if (i_start) state_d = RUN;
            RUN:   if (last_smp) state_d = DRAIN;
            DRAIN: begin
                if (pipe_idle && fifo_empty) begin
                    o_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy     = (state_q != IDLE);
    assign o_overflow = ovf_q;

    // Coordinates advance on every accepted sample, including ones later dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bias_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (start_ok) begin
            bias_q <= i_bias;
            row_q  <= '0;
            col_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (col_q == LAST_IDX) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign sum_ext = $signed({s1_sum[SUM_W-1], s1_sum});

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [R_W-1:0] HALF = R_W'(1) << (SHIFT - 1);
            assign s2_next = (sum_ext + HALF) >>> SHIFT;
        end else begin : g_pass
            assign s2_next = sum_ext;
        end
    endgenerate

    always_comb begin
        sat_d = s2_r[OUT_WIDTH-1:0];
        if (s2_r > SAT_MAX) begin
            sat_d = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s2_r < SAT_MIN) begin
            sat_d = SAT_MIN[OUT_WIDTH-1:0];
        end
`ifdef CONV_OUT_RELU_EN
        if (sat_d[OUT_WIDTH-1]) begin
            sat_d = '0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
            s1_sum <= '0;
            s2_r   <= '0;
            s3_dat <= '0;
            s1_row <= '0;
            s1_col <= '0;
            s2_row <= '0;
            s2_col <= '0;
            s3_row <= '0;
            s3_col <= '0;
        end else begin
            s1_vld <= accept;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
            if (accept) begin
                s1_sum <= {i_P[P_WIDTH-1], i_P} + {{(SUM_W - BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};
                s1_row <= row_q;
                s1_col <= col_q;
            end
            if (s1_vld) begin
                s2_r   <= s2_next;
                s2_row <= s1_row;
                s2_col <= s1_col;
            end
            if (s2_vld) begin
                s3_dat <= sat_d;
                s3_row <= s2_row;
                s3_col <= s2_col;
            end
        end
    end

    conv_result_fifo #(
        .WIDTH (PL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (s3_vld),
        .i_dat   ({s3_row, s3_col, s3_dat}),
        .i_pop   (pop),
        .o_dat   (fifo_dat),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_valid = !fifo_empty;
    assign {o_row, o_col, o_data} = fifo_dat;

endmodule

// File: tb/tb_conv_out_requant.sv
// Scoreboarded bench for conv_out_requant: directed rounding/saturation/backpressure/reset cases plus random frames.
module tb_conv_out_requant;

    localparam int FM_SIZE     = 4;
    localparam int KERNEL_SIZE = 3;
    localparam int PADDING     = 0;
    localparam int STRIDE      = 1;
    localparam int OUT_WIDTH   = 8;
    localparam int SHIFT       = 4;
    localparam int FIFO_DEPTH  = 2;
    localparam int OUT_SIZE    = (FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1;
    localparam int CW          = $clog2(OUT_SIZE) + 1;
    localparam int NSAMP       = OUT_SIZE * OUT_SIZE;
    localparam int WW          = 2 * CW + OUT_WIDTH;

    logic                 i_clk;
    logic                 i_rst_n;
    logic                 i_start;
    logic [31:0]          i_bias;
    logic signed [47:0]   i_P;
    logic                 i_P_valid;
    logic [OUT_WIDTH-1:0] o_data;
    logic [CW-1:0]        o_row;
    logic [CW-1:0]        o_col;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_overflow;

    conv_out_requant #(
        .FM_SIZE     (FM_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE),
        .PADDING     (PADDING),
        .STRIDE      (STRIDE),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT       (SHIFT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_bias     (i_bias),
        .i_P        (i_P),
        .i_P_valid  (i_P_valid),
        .o_data     (o_data),
        .o_row      (o_row),
        .o_col      (o_col),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int           total = 0;
    int           bad = 0;
    int           issued = 0;
    int           popped = 0;
    int           sidx = 0;
    longint       cur_bias = 0;
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] prev_w;
    bit           prev_stall = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, floor-based rounding, clamp, optional ReLU.
    function automatic logic [OUT_WIDTH-1:0] model(input longint p, input longint b);
        longint s, hi, lo;
        s = p + b;
        if (SHIFT > 0) s = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        hi = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        lo = -hi - 1;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`ifdef CONV_OUT_RELU_EN
        if (s < 0) s = 0;
`endif
        return OUT_WIDTH'(s);
    endfunction

    // mode: 0 ignored by DUT, 1 expect model value, 2 expect expd, 3 accepted but dropped
    task automatic drive(input logic signed [47:0] p, input int mode, input int expd);
        logic [CW-1:0]        r;
        logic [CW-1:0]        c;
        logic [OUT_WIDTH-1:0] d;
        r = CW'(sidx / OUT_SIZE);
        c = CW'(sidx % OUT_SIZE);
        d = (mode == 1) ? model(longint'(p), cur_bias) : OUT_WIDTH'(expd);
        if (mode == 1 || mode == 2) begin
            exp_q.push_back({r, c, d});
            issued++;
        end
        if (mode != 0) sidx++;
        i_P = p;
        i_P_valid = 1'b1;
        @(posedge i_clk); #1;
        i_P_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic start_frame(input longint b);
        cur_bias = b;
        sidx = 0;
        i_bias = 32'(b);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        int n;
        seen = 0;
        n = 0;
        while (!seen && n < 300) begin
            @(negedge i_clk);
            if (o_done) seen = 1;
            n++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got no o_done want pulse", nm);
        end else begin
            check({nm, "_busy_at_done"}, 64'(o_busy), 64'd1);
            @(negedge i_clk);
            check({nm, "_busy_after_done"}, 64'(o_busy), 64'd0);
            check({nm, "_done_one_cycle"}, 64'(o_done), 64'd0);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_valid"}, 64'(o_valid), 64'd0);
        check({nm, "_busy"}, 64'(o_busy), 64'd0);
        check({nm, "_done"}, 64'(o_done), 64'd0);
        check({nm, "_overflow"}, 64'(o_overflow), 64'd0);
        check({nm, "_data"}, 64'(o_data), 64'd0);
        check({nm, "_row"}, 64'(o_row), 64'd0);
        check({nm, "_col"}, 64'(o_col), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer, and checks head stability under stall.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(o_valid), 64'd1);
                check("stall_word", 64'({o_row, o_col, o_data}), 64'(prev_w));
            end
            if (o_valid && i_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", {o_row, o_col, o_data});
                end else begin
                    check("word", 64'({o_row, o_col, o_data}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_w = {o_row, o_col, o_data};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end want finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int cyc;
        logic signed [47:0] p;
        longint b;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_bias = '0;
        i_P = '0;
        i_P_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        idle(2);

        // Rounding
        start_frame(8);
        drive(48'sd24, 2, 2);
        drive(48'sd7, 2, 1);
`ifdef CONV_OUT_RELU_EN
        drive(-48'sd100, 2, 0);
`else
        drive(-48'sd100, 2, -6);
`endif
        drive(48'sd0, 2, 1);
        wait_done("round");

        // Saturation
        start_frame(0);
        drive(48'sh0000_0010_0000, 2, 127);
`ifdef CONV_OUT_RELU_EN
        drive(-48'sh0000_0010_0000, 2, 0);
        drive(48'sd48, 2, 3);
        drive(-48'sd48, 2, 0);
`else
        drive(-48'sh0000_0010_0000, 2, -128);
        drive(48'sd48, 2, 3);
        drive(-48'sd48, 2, -3);
`endif
        wait_done("sat");

        // Ignore rules and latency
        drive(48'sd55, 0, 0);
        idle(6);
        start_frame(16);
        drive(48'sd32, 1, 0);
        lat = 1;
        while (lat < 20) begin
            @(negedge i_clk);
            if (o_valid) break;
            @(posedge i_clk);
            lat++;
        end
        check("latency_edges", 64'(lat), 64'd4);
        @(posedge i_clk); #1;
        i_bias = 32'd1000;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        drive(48'sd100, 1, 0);
        drive(-48'sd60, 1, 0);
        drive(48'sd500, 1, 0);
        drive(48'sd77, 0, 0);
        wait_done("ignore");
        idle(4);

        // Backpressure with overflow
        i_ready = 1'b0;
        start_frame(0);
        drive(48'sd160, 2, 10);
        drive(48'sd320, 2, 20);
        drive(48'sd480, 3, 0);
        drive(48'sd640, 3, 0);
        idle(8);
        @(negedge i_clk);
        check("bp_overflow", 64'(o_overflow), 64'd1);
        check("bp_valid", 64'(o_valid), 64'd1);
        check("bp_head", 64'(o_data), 64'd10);
        check("bp_busy", 64'(o_busy), 64'd1);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        wait_done("bp");

        // Reset mid-frame
        start_frame(5);
        @(negedge i_clk);
        check("ovf_cleared", 64'(o_overflow), 64'd0);
        @(posedge i_clk); #1;
        drive(48'sd100, 1, 0);
        drive(48'sd200, 1, 0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        issued = popped;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        idle(2);
        start_frame(-3);
        drive(48'sd1000, 1, 0);
        drive(-48'sd1000, 1, 0);
        drive(48'sd20, 1, 0);
        drive(-48'sd20, 1, 0);
        wait_done("postrst");

        // Random frames with random backpressure; issue only while in-flight < FIFO_DEPTH
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 0) b = longint'($signed(32'($urandom)));
            else b = longint'($urandom_range(0, 400)) - 200;
            start_frame(b);
            n = 0;
            cyc = 0;
            while (n < NSAMP && cyc < 500) begin
                i_ready = ($urandom_range(0, 3) != 0);
                if ((issued - popped) < FIFO_DEPTH && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 2))
                        0: p = {16'($urandom), 32'($urandom)};
                        1: p = 48'(int'($urandom_range(0, 10000)) - 5000);
                        default: p = 48'(int'($urandom_range(0, 200)) - 100 + (($urandom_range(0, 1) == 1) ? 2032 : -2048) - int'(b));
                    endcase
                    drive(p, 1, 0);
                    n++;
                end else begin
                    idle(1);
                end
                cyc++;
            end
            check("rand_issued_all", 64'(n), 64'(NSAMP));
            i_ready = 1'b1;
            wait_done("rand");
            check("rand_no_overflow", 64'(o_overflow), 64'd0);
        end

        idle(4);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
